// File: rtl/bitser_pkg.sv
// Shared types for the bit-serial adder sequencer.
// FSM state encoding (IDLE, RUN, DONE).
package bitser_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/add1b.sv
// Single-bit full adder cell: a + b + ci -> r, co.
// Ports: a, b, ci in; r (sum), co (carry out) out.
module add1b (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic r,
  output logic co
);

  assign r  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/bitser_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one add1b cell, LSB first, WIDTH+1 cycles.
// Ports: clk, rst_n, start, op_a, op_b, [op_sub with BITSER_SUB_EN] in;
// busy, done, result, carry, ovf, zero out.
module bitser_add_ctrl
  import bitser_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
`ifdef BITSER_SUB_EN
  input  logic             op_sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf,
  output logic             zero
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;
  logic [CNT_W-1:0] cnt_q;
  logic             creg_q;
  logic             carry_q;
  logic             ovf_q;
  logic             zero_q;

  logic sub_in;
  logic accept;
  logic step;
  logic last;
  logic cell_r;
  logic cell_co;

`ifdef BITSER_SUB_EN
  assign sub_in = op_sub;
`else
  assign sub_in = 1'b0;
`endif

  assign accept = (state_q == IDLE) && start;
  assign step   = (state_q == RUN);
  assign last   = step && (cnt_q == LAST);
  assign sr_d   = {cell_r, sr_q[WIDTH-1:1]};

  add1b u_cell (
    .a  (sa_q[0]),
    .b  (sb_q[0]),
    .ci (creg_q),
    .r  (cell_r),
    .co (cell_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (1'b1)
      (state_q == RUN):  busy = 1'b1;
      (state_q == DONE): done = 1'b1;
      default: ;
    endcase
  end

  // Subtraction is A + ~B + 1: invert B and seed the carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
      creg_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (accept) begin
      sa_q    <= op_a;
      sb_q    <= sub_in ? ~op_b : op_b;
      creg_q  <= sub_in;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (step) begin
      sr_q   <= sr_d;
      sa_q   <= sa_q >> 1;
      sb_q   <= sb_q >> 1;
      creg_q <= cell_co;
      cnt_q  <= cnt_q + CNT_W'(1);
      if (last) begin
        carry_q <= cell_co;
        // carry into MSB xor carry out of MSB
        ovf_q   <= creg_q ^ cell_co;
        zero_q  <= (sr_d == '0);
      end
    end
  end

  assign result = sr_q;
  assign carry  = carry_q;
  assign ovf    = ovf_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_bitser_add_ctrl.sv
// Self-checking bench for bitser_add_ctrl (WIDTH=8).
// Random + directed stimulus against an arithmetic reference model.
module tb_bitser_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_sub;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry;
  logic         ovf;
  logic         zero;

  int checks = 0;
  int errors = 0;

  bitser_add_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op_a   (op_a),
    .op_b   (op_b),
`ifdef BITSER_SUB_EN
    .op_sub (op_sub),
`endif
    .busy   (busy),
    .done   (done),
    .result (result),
    .carry  (carry),
    .ovf    (ovf),
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on W bits.
  function automatic logic [W+2:0] ref_op(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic s);
    int unsigned bb;
    int unsigned sum;
    logic [W-1:0] r;
    logic c;
    logic v;
    logic z;
    bb  = s ? ((~int'(b)) & ((1 << W) - 1)) : int'(b);
    sum = int'(a) + bb + (s ? 1 : 0);
    r   = W'(sum);
    c   = sum[W];
    v   = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
    z   = (r == 0);
    return {r, c, v, z};
  endfunction

  // Timing model: m_rem counts cycles left in an operation.
  // >=2 busy, 1 done cycle, 0 idle.
  int           m_rem;
  logic [W-1:0] m_r;
  logic         m_c, m_v, m_z;
  logic [W+2:0] pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem = 0;
      m_r = '0;
      m_c = 1'b0;
      m_v = 1'b0;
      m_z = 1'b0;
    end else if (m_rem == 0) begin
      if (start) begin
        m_rem = W + 1;
        pend  = ref_op(op_a, op_b, op_sub);
        m_c = 1'b0;
        m_v = 1'b0;
        m_z = 1'b0;
      end
    end else begin
      m_rem = m_rem - 1;
      if (m_rem == 1) begin
        {m_r, m_c, m_v, m_z} = pend;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", busy, m_rem >= 2);
      chk("done", done, m_rem == 1);
      if (m_rem <= 1) chk("result", result, m_r);
      chk("carry", carry, m_c);
      chk("ovf", ovf, m_v);
      chk("zero", zero, m_z);
    end
  end

  task automatic do_op(input string nm,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input logic s,
                       input logic [W-1:0] er,
                       input logic ec, ev, ez);
    int lat;
    int bz;
    @(negedge clk);
    start = 1'b1;
    op_a = a;
    op_b = b;
    op_sub = s;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    bz = busy ? 1 : 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy) bz++;
    end
    chk({nm, "_lat"}, lat, W + 1);
    chk({nm, "_busycyc"}, bz, W);
    chk({nm, "_res"}, result, er);
    chk({nm, "_carry"}, carry, ec);
    chk({nm, "_ovf"}, ovf, ev);
    chk({nm, "_zero"}, zero, ez);
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_res"}, result, 0);
    chk({nm, "_carry"}, carry, 0);
    chk({nm, "_ovf"}, ovf, 0);
    chk({nm, "_zero"}, zero, 0);
  endtask

  initial begin
    int nd;
    int d1;
    int d2;
    rst_n = 1'b0;
    start = 1'b0;
    op_a = '0;
    op_b = '0;
    op_sub = 1'b0;
    #12;
    check_all_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;

    do_op("a35_4a", 8'h35, 8'h4A, 1'b0, 8'h7F, 0, 0, 0);
    do_op("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1, 0, 1);
    do_op("7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 0, 1, 0);
    do_op("80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1, 1, 1);

    // Spurious start during RUN is ignored.
    @(negedge clk);
    start = 1'b1;
    op_a = 8'h12;
    op_b = 8'h34;
    @(negedge clk);
    start = 1'b0;
    nd = 0;
    for (int i = 0; i < 14; i++) begin
      if (i == 2) begin
        start = 1'b1;
        op_a = 8'hFF;
        op_b = 8'hFF;
      end else begin
        start = 1'b0;
      end
      if (done) nd++;
      @(negedge clk);
    end
    chk("ign_ndone", nd, 1);
    chk("ign_res", result, 8'h46);

    // Held start: back-to-back ops every W+2 cycles.
    start = 1'b1;
    op_a = 8'h10;
    op_b = 8'h20;
    d1 = -1;
    d2 = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        if (d1 < 0) d1 = i;
        else if (d2 < 0) d2 = i;
      end
    end
    chk("held_gap", d2 - d1, W + 2);
    start = 1'b0;
    repeat (12) @(negedge clk);

    // Async reset mid-RUN discards the op.
    start = 1'b1;
    op_a = 8'h55;
    op_b = 8'h0F;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    @(negedge clk);
    #2 rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("midrst_ndone", nd, 0);
    do_op("01_02", 8'h01, 8'h02, 1'b0, 8'h03, 0, 0, 0);

`ifdef BITSER_SUB_EN
    do_op("s05_07", 8'h05, 8'h07, 1'b1, 8'hFE, 0, 0, 0);
    do_op("s80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1, 1, 0);
    do_op("s10_10", 8'h10, 8'h10, 1'b1, 8'h00, 1, 0, 1);
`endif

    // Random traffic, including starts during RUN/DONE.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      op_a = W'($urandom);
      op_b = W'($urandom);
`ifdef BITSER_SUB_EN
      op_sub = $urandom_range(0, 1) == 1;
`else
      op_sub = 1'b0;
`endif
    end
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
